tlb_search_arbiter: RTL
=======================

Name: tlb_search_arbiter

Overview:
- Shares the single search port of the main (joint) TLB between two requesters: ITLB-buffer refill from the pre-IF stage and DTLB-buffer refill from the memory stage.
- Sequences each lookup, returns results to the winning requester, and keeps the search port off while CP0 TLB writes (tlbwi/tlbwr/tlbp) own the TLB.
- Cancels in-flight work on pipeline flush.

Parameters:
- VPN2_W, 19, width of VPN2 (VA[31:13]).
- ASID_W, 4, width of ASID.
- IDX_W, 4, TLB index width (16 entries).
- PFN_W, 20, PFN width.
- STARVE_LIMIT, 3, consecutive I-side losses before I-side is forced to win.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- flush  in  1  pipeline flush (exception/eret)
- tlb_op_busy  in  1  CP0 TLB instruction owns the TLB; no new grants
- i_req  in  1  ITLB-buffer miss request, level, held until i_resp_valid
- i_va  in  32  fetch VA (prefs_pc)
- d_req  in  1  DTLB-buffer miss request, level, held until d_resp_valid
- d_va  in  32  data VA
- cur_asid  in  ASID_W  EntryHi.ASID
- s_valid  out  1  search strobe to TLB
- s_vpn2  out  VPN2_W  search VPN2
- s_odd  out  1  odd-page select (VA[12])
- s_asid  out  ASID_W  search ASID
- s_found  in  1  TLB hit (valid cycle after s_valid)
- s_index  in  IDX_W  hit index
- s_pfn  in  PFN_W  PFN
- s_c  in  3  cache attribute
- s_d  in  1  dirty
- s_v  in  1  valid
- i_resp_valid  out  1  one-cycle result pulse to ITLB buffer
- d_resp_valid  out  1  one-cycle result pulse to DTLB buffer
- resp_found  out  1  registered result
- resp_index  out  IDX_W  registered result
- resp_pfn  out  PFN_W  registered result
- resp_c  out  3  registered result
- resp_d  out  1  registered result
- resp_v  out  1  registered result
- busy  out  1  state != IDLE

Behaviour:
- Reset (async): state=IDLE, owner=0 (I), starve_cnt=0; all outputs 0.
- FSM IDLE -> SEARCH -> RESP -> IDLE.
- IDLE: grant only if (i_req|d_req) & ~tlb_op_busy & ~flush.
  - Winner: D-side, unless starve_cnt==STARVE_LIMIT and i_req, in which case I wins.
  - Latch owner and owner's VA/cur_asid into a request register; go SEARCH.
- starve_cnt: +1 when D wins while i_req is high; cleared when I is granted or i_req is low; saturates at STARVE_LIMIT.
- SEARCH (1 cycle):
  - s_valid=1; s_vpn2=VA[31:13], s_odd=VA[12], s_asid taken from the request register.
  - s_* outputs are 0 in all other states.
  - Go RESP.
- RESP (1 cycle):
  - Capture s_found/index/pfn/c/d/v into resp_*.
  - Pulse owner's resp_valid on the following cycle (registered).
  - Return to IDLE.
- Latency: request high in IDLE cycle T -> s_valid at T+1 -> resp_valid at T+3. Back-to-back grant possible at T+3.
- resp_* hold their value until the next capture. resp_valid is never high for both sides at once.
- flush in SEARCH or RESP: go IDLE next cycle, suppress resp_valid, keep starve_cnt. Flush in IDLE blocks the grant that cycle.
- tlb_op_busy affects only IDLE grants; an in-flight lookup completes.
- Requester dropping req mid-lookup: lookup completes and the pulse still issues; requester ignores it.
- Simultaneous i_req and d_req with starve_cnt<limit: D wins, I waits.

Test Plan:
- Single I request, i_va=0x8000_3000, TLB returns found=1, index=5, pfn=0x12345, v=1.
  -> s_valid at T+1 with s_vpn2=0x40001, s_odd=1.
  -> i_resp_valid at T+3 with resp_index=5, resp_pfn=0x12345; d_resp_valid stays 0.
- i_req and d_req both held high continuously.
  -> Grants D,D,D,I,D,D,D,I...; starve_cnt returns to 0 after each I grant.
- flush asserted during SEARCH of a D lookup.
  -> state IDLE next cycle, no d_resp_valid.
  -> Pending i_req granted once flush is low.
- tlb_op_busy high for 5 cycles with i_req high.
  -> No s_valid during those cycles; grant on the first cycle busy is low.
- Miss case, s_found=0.
  -> i_resp_valid pulses with resp_found=0 (requester raises refill exception).
- Asynchronous reset asserted mid-RESP.
  -> Outputs 0 immediately, state IDLE, no response pulse after reset is released.

Source files
------------

// File: rtl/tlb_search_arbiter.sv
// tlb_search_arbiter: shares the joint-TLB search port between the ITLB-buffer
// refill (pre-IF) and the DTLB-buffer refill (MEM). Each lookup runs
// IDLE -> SEARCH -> RESP; the result is registered and returned to the winner
// as a one-cycle pulse. D-side normally wins, but I-side is forced through
// after STARVE_LIMIT consecutive losses. CP0 TLB ops block new grants and a
// pipeline flush cancels the in-flight lookup.
module tlb_search_arbiter #(
    parameter int unsigned VPN2_W       = 19,
    parameter int unsigned ASID_W       = 4,
    parameter int unsigned IDX_W        = 4,
    parameter int unsigned PFN_W        = 20,
    parameter int unsigned STARVE_LIMIT = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              tlb_op_busy,
    input  logic              i_req,
    input  logic [31:0]       i_va,
    input  logic              d_req,
    input  logic [31:0]       d_va,
    input  logic [ASID_W-1:0] cur_asid,
    output logic              s_valid,
    output logic [VPN2_W-1:0] s_vpn2,
    output logic              s_odd,
    output logic [ASID_W-1:0] s_asid,
    input  logic              s_found,
    input  logic [IDX_W-1:0]  s_index,
    input  logic [PFN_W-1:0]  s_pfn,
    input  logic [2:0]        s_c,
    input  logic              s_d,
    input  logic              s_v,
    output logic              i_resp_valid,
    output logic              d_resp_valid,
    output logic              resp_found,
    output logic [IDX_W-1:0]  resp_index,
    output logic [PFN_W-1:0]  resp_pfn,
    output logic [2:0]        resp_c,
    output logic              resp_d,
    output logic              resp_v,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        RESP   = 2'd2
    } state_e;

    // Owner encoding: 0 = I-side, 1 = D-side.
    localparam logic OWNER_I = 1'b0;
    localparam logic OWNER_D = 1'b1;

    localparam int unsigned CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

    state_e state_q, state_d;

    logic              owner_q, owner_d;
    logic [VPN2_W-1:0] req_vpn2_q, req_vpn2_d;
    logic              req_odd_q, req_odd_d;
    logic [ASID_W-1:0] req_asid_q, req_asid_d;
    logic [CNT_W-1:0]  starve_q, starve_d;

    logic              i_resp_valid_q, i_resp_valid_d;
    logic              d_resp_valid_q, d_resp_valid_d;
    logic              resp_found_q, resp_found_d;
    logic [IDX_W-1:0]  resp_index_q, resp_index_d;
    logic [PFN_W-1:0]  resp_pfn_q, resp_pfn_d;
    logic [2:0]        resp_c_q, resp_c_d;
    logic              resp_d_q, resp_d_d;
    logic              resp_v_q, resp_v_d;

    logic              grant;
    logic              grant_i;
    logic [31:0]       win_va;

    // Page offset bits never take part in the search.
    logic unused_va_low;
    assign unused_va_low = ^{i_va[11:0], d_va[11:0]};

    // Arbitration: grant only from IDLE, I-side wins when alone or when starved.
    always_comb begin
        grant   = (i_req | d_req) & ~tlb_op_busy & ~flush & (state_q == IDLE);
        grant_i = i_req & (~d_req | (starve_q == CNT_MAX));
        win_va  = grant_i ? i_va : d_va;
    end

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state: one cycle each in SEARCH and RESP; flush aborts SEARCH.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (grant) state_d = SEARCH;
            SEARCH:  state_d = flush ? IDLE : RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath registers: request latch, starvation counter, result capture.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            owner_q        <= OWNER_I;
            req_vpn2_q     <= '0;
            req_odd_q      <= 1'b0;
            req_asid_q     <= '0;
            starve_q       <= '0;
            i_resp_valid_q <= 1'b0;
            d_resp_valid_q <= 1'b0;
            resp_found_q   <= 1'b0;
            resp_index_q   <= '0;
            resp_pfn_q     <= '0;
            resp_c_q       <= '0;
            resp_d_q       <= 1'b0;
            resp_v_q       <= 1'b0;
        end else begin
            owner_q        <= owner_d;
            req_vpn2_q     <= req_vpn2_d;
            req_odd_q      <= req_odd_d;
            req_asid_q     <= req_asid_d;
            starve_q       <= starve_d;
            i_resp_valid_q <= i_resp_valid_d;
            d_resp_valid_q <= d_resp_valid_d;
            resp_found_q   <= resp_found_d;
            resp_index_q   <= resp_index_d;
            resp_pfn_q     <= resp_pfn_d;
            resp_c_q       <= resp_c_d;
            resp_d_q       <= resp_d_d;
            resp_v_q       <= resp_v_d;
        end
    end

    // Datapath next-state: latch winner on grant, capture TLB result in RESP.
    always_comb begin
        owner_d        = owner_q;
        req_vpn2_d     = req_vpn2_q;
        req_odd_d      = req_odd_q;
        req_asid_d     = req_asid_q;
        starve_d       = starve_q;
        i_resp_valid_d = 1'b0;
        d_resp_valid_d = 1'b0;
        resp_found_d   = resp_found_q;
        resp_index_d   = resp_index_q;
        resp_pfn_d     = resp_pfn_q;
        resp_c_d       = resp_c_q;
        resp_d_d       = resp_d_q;
        resp_v_d       = resp_v_q;

        if (grant) begin
            owner_d    = grant_i ? OWNER_I : OWNER_D;
            req_vpn2_d = VPN2_W'(win_va[31:13]);
            req_odd_d  = win_va[12];
            req_asid_d = cur_asid;
        end

        // Counts consecutive D wins over a waiting I; any gap in i_req resets it.
        if (!i_req) begin
            starve_d = '0;
        end else if (grant && grant_i) begin
            starve_d = '0;
        end else if (grant && (starve_q != CNT_MAX)) begin
            starve_d = starve_q + CNT_W'(1);
        end

        // A flush during RESP drops the result entirely, leaving resp_* as they were.
        if ((state_q == RESP) && !flush) begin
            resp_found_d   = s_found;
            resp_index_d   = s_index;
            resp_pfn_d     = s_pfn;
            resp_c_d       = s_c;
            resp_d_d       = s_d;
            resp_v_d       = s_v;
            i_resp_valid_d = (owner_q == OWNER_I);
            d_resp_valid_d = (owner_q == OWNER_D);
        end
    end

    // Outputs: search port is driven only in SEARCH; results come from flops.
    always_comb begin
        s_valid      = (state_q == SEARCH);
        s_vpn2       = (state_q == SEARCH) ? req_vpn2_q : '0;
        s_odd        = (state_q == SEARCH) ? req_odd_q  : 1'b0;
        s_asid       = (state_q == SEARCH) ? req_asid_q : '0;
        busy         = (state_q != IDLE);
        i_resp_valid = i_resp_valid_q;
        d_resp_valid = d_resp_valid_q;
        resp_found   = resp_found_q;
        resp_index   = resp_index_q;
        resp_pfn     = resp_pfn_q;
        resp_c       = resp_c_q;
        resp_d       = resp_d_q;
        resp_v       = resp_v_q;
    end

endmodule
